// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and transmitter-side signals around the UART TX arbiter.
// The slave modport is the arbiter itself; master is the surrounding producers/transmitter.
interface uart_tx_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DBITS = 8
);
    localparam int GNT_W = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DBITS-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic [DBITS-1:0]      tx_data;
    logic                  tx_start;
    logic                  tx_busy;
    logic [GNT_W-1:0]      gnt_id;
    logic                  arb_busy;
    logic                  err_tmo;
    logic                  err_clr;

    modport slave (
        input  req_valid, req_data, tx_busy, err_clr,
        output req_ready, tx_data, tx_start, gnt_id, arb_busy, err_tmo
    );

    modport master (
        output req_valid, req_data, tx_busy, err_clr,
        input  req_ready, tx_data, tx_start, gnt_id, arb_busy, err_tmo
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NREQ byte producers, one frame at a time.
// Define UART_TX_ARB_FIXED_PRIO_EN for fixed lowest-index priority; default is round-robin.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DBITS   = 8,
    parameter int ACK_TMO = 64
) (
    input  logic                sysclk,
    input  logic                rst,
    uart_tx_arbiter_if.slave    bus
);
    localparam int GNT_W = $clog2(NREQ);
    localparam int TMO_W = $clog2(ACK_TMO) + 1;

    localparam logic [4:0] sIDLE  = 5'b00001;
    localparam logic [4:0] sGRANT = 5'b00010;
    localparam logic [4:0] sSTART = 5'b00100;
    localparam logic [4:0] sACK   = 5'b01000;
    localparam logic [4:0] sDONE  = 5'b10000;

    logic [4:0]       state;
    logic [TMO_W-1:0] tmo_cnt;
    logic             win_found;
    logic [GNT_W-1:0] win_id;
    logic [NREQ-1:0]  win_onehot;
    logic [DBITS-1:0] win_data;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                win_found = 1'b1;
                win_id    = GNT_W'(i);
            end
        end
    end
`else
    logic [GNT_W-1:0] rr_ptr;
    logic [GNT_W:0]   rr_cand;

    // Scan from the farthest candidate back to ptr+1 so the nearest valid one wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        rr_cand   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            rr_cand = {1'b0, rr_ptr} + (GNT_W + 1)'(k);
            if (rr_cand >= (GNT_W + 1)'(NREQ))
                rr_cand = rr_cand - (GNT_W + 1)'(NREQ);
            if (bus.req_valid[rr_cand[GNT_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = rr_cand[GNT_W-1:0];
            end
        end
    end
`endif

    always_comb begin
        win_onehot         = '0;
        win_onehot[win_id] = win_found;
        win_data           = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (GNT_W'(i) == win_id)
                win_data = bus.req_data[i*DBITS +: DBITS];
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state         <= sIDLE;
            bus.req_ready <= '0;
            bus.tx_start  <= 1'b0;
            bus.tx_data   <= '0;
            bus.gnt_id    <= '0;
            bus.arb_busy  <= 1'b0;
            bus.err_tmo   <= 1'b0;
            tmo_cnt       <= '0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
            rr_ptr        <= GNT_W'(NREQ - 1);
`endif
        end else begin
            // A timeout set later in this block overrides the clear.
            if (bus.err_clr)
                bus.err_tmo <= 1'b0;

            case (state)
                sIDLE: begin
                    if (win_found && !bus.tx_busy) begin
                        bus.tx_data   <= win_data;
                        bus.gnt_id    <= win_id;
                        bus.req_ready <= win_onehot;
                        bus.arb_busy  <= 1'b1;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
                        rr_ptr        <= win_id;
`endif
                        state         <= sGRANT;
                    end
                end
                sGRANT: begin
                    bus.req_ready <= '0;
                    bus.tx_start  <= 1'b1;
                    state         <= sSTART;
                end
                sSTART: begin
                    bus.tx_start <= 1'b0;
                    tmo_cnt      <= '0;
                    state        <= sACK;
                end
                sACK: begin
                    if (bus.tx_busy) begin
                        state <= sDONE;
                    end else if (tmo_cnt == TMO_W'(ACK_TMO - 1)) begin
                        bus.err_tmo  <= 1'b1;
                        bus.arb_busy <= 1'b0;
                        state        <= sIDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                sDONE: begin
                    // Frame length depends on baud rate, so no timeout here.
                    if (!bus.tx_busy) begin
                        bus.arb_busy <= 1'b0;
                        state        <= sIDLE;
                    end
                end
                default: begin
                    bus.req_ready <= '0;
                    bus.tx_start  <= 1'b0;
                    bus.arb_busy  <= 1'b0;
                    state         <= sIDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, directed multi-cycle sequences and random traffic
// against a transaction-level model. Honours UART_TX_ARB_FIXED_PRIO_EN like the design.
module tb_uart_tx_arbiter;
    localparam int NREQ    = 4;
    localparam int DBITS   = 8;
    localparam int ACK_TMO = 64;

    logic sysclk = 1'b0;
    logic rst    = 1'b1;
    always #5 sysclk = ~sysclk;

    uart_tx_arbiter_if #(.NREQ(NREQ), .DBITS(DBITS)) bus();

    uart_tx_arbiter #(.NREQ(NREQ), .DBITS(DBITS), .ACK_TMO(ACK_TMO)) dut (
        .sysclk (sysclk),
        .rst    (rst),
        .bus    (bus)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        int          busy_len;
        logic [3:0]  exp_ready;
        logic [1:0]  exp_gnt;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;

    // Random-phase model state
    logic [7:0]  dat[NREQ];
    logic [3:0]  pending, v, exp_ready;
    logic [31:0] d;
    logic [1:0]  last_gnt;
    logic [7:0]  last_data;
    logic [7:0]  rr_bytes[NREQ];
    int free_from, busy_on, busy_off, start_at, grant_edge, last_rr, w;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data,
                                 input logic busy, input logic clr);
        bus.req_valid = valid;
        bus.req_data  = data;
        bus.tx_busy   = busy;
        bus.err_clr   = clr;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(4'b0000, 32'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    // Expected winner from the arbitration rule, given the last grant.
    function automatic int pick(input int last, input logic [3:0] vv);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++)
            if (vv[i]) return i;
`else
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (last + k) % NREQ;
            if (vv[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic runFrame(input string name, input logic [3:0] vv, input logic [31:0] dd,
                            input int blen, input logic [3:0] er, input logic [1:0] eg,
                            input logic [7:0] ed, input logic keep);
        applyStimulus(vv, dd, 1'b0, 1'b0);
        tick();
        checkOutput({name, "_ready"}, 32'(bus.req_ready), 32'(er));
        checkOutput({name, "_gnt"}, 32'(bus.gnt_id), 32'(eg));
        checkOutput({name, "_data"}, 32'(bus.tx_data), 32'(ed));
        checkOutput({name, "_start0"}, 32'(bus.tx_start), 32'h0);
        checkOutput({name, "_abusy"}, 32'(bus.arb_busy), 32'h1);
        if (!keep) bus.req_valid = vv & ~er;
        tick();
        checkOutput({name, "_readyoff"}, 32'(bus.req_ready), 32'h0);
        checkOutput({name, "_start"}, 32'(bus.tx_start), 32'h1);
        tick();
        checkOutput({name, "_startoff"}, 32'(bus.tx_start), 32'h0);
        bus.tx_busy = 1'b1;
        repeat (blen) tick();
        checkOutput({name, "_inframe"}, 32'(bus.arb_busy), 32'h1);
        bus.tx_busy = 1'b0;
        tick();
        checkOutput({name, "_idle"}, 32'(bus.arb_busy), 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{4'b0100, 32'h00A5_0000, 10, 4'b0100, 2'd2, 8'hA5};
        vecs[1] = '{4'b0001, 32'h1111_1134, 3,  4'b0001, 2'd0, 8'h34};
        vecs[2] = '{4'b1000, 32'hC300_0000, 1,  4'b1000, 2'd3, 8'hC3};
        vecs[3] = '{4'b1010, 32'h7E00_5A00, 5,  4'b0010, 2'd1, 8'h5A};
        vecs[4] = '{4'b0110, 32'h0099_4200, 2,  4'b0010, 2'd1, 8'h42};
        vecs[5] = '{4'b1001, 32'hF000_000F, 4,  4'b0001, 2'd0, 8'h0F};

        // Reset state
        applyStimulus(4'b0000, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("rst_ready", 32'(bus.req_ready), 32'h0);
        checkOutput("rst_start", 32'(bus.tx_start), 32'h0);
        checkOutput("rst_data", 32'(bus.tx_data), 32'h0);
        checkOutput("rst_gnt", 32'(bus.gnt_id), 32'h0);
        checkOutput("rst_abusy", 32'(bus.arb_busy), 32'h0);
        checkOutput("rst_err", 32'(bus.err_tmo), 32'h0);
        rst = 1'b0;

        // Table of single transactions, each from a fresh reset
        for (int i = 0; i < 6; i++) begin
            doReset();
            runFrame($sformatf("vec%0d", i), vecs[i].valid, vecs[i].data, vecs[i].busy_len,
                     vecs[i].exp_ready, vecs[i].exp_gnt, vecs[i].exp_data, 1'b0);
        end

        // Fairness with all requesters continuously pending
        doReset();
        rr_bytes[0] = 8'h11; rr_bytes[1] = 8'h22; rr_bytes[2] = 8'h33; rr_bytes[3] = 8'h44;
        for (int n = 0; n < 5; n++) begin
            int ww;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
            ww = 0;
`else
            ww = n % NREQ;
`endif
            runFrame($sformatf("rr%0d", n), 4'b1111,
                     {rr_bytes[3], rr_bytes[2], rr_bytes[1], rr_bytes[0]}, 2,
                     4'(4'b0001 << ww), 2'(ww), rr_bytes[ww], 1'b1);
            rr_bytes[ww] = rr_bytes[ww] + 8'h10;
        end

        // Timeout: tx_busy never rises
        doReset();
        applyStimulus(4'b0001, 32'h0000_0055, 1'b0, 1'b0);
        tick();
        checkOutput("tmo_ready", 32'(bus.req_ready), 32'h1);
        bus.req_valid = 4'b0000;
        tick();
        tick();
        repeat (ACK_TMO - 1) tick();
        checkOutput("tmo_early_err", 32'(bus.err_tmo), 32'h0);
        checkOutput("tmo_early_abusy", 32'(bus.arb_busy), 32'h1);
        tick();
        checkOutput("tmo_err", 32'(bus.err_tmo), 32'h1);
        checkOutput("tmo_abusy", 32'(bus.arb_busy), 32'h0);

        // Sticky error does not block arbitration
        runFrame("errgo", 4'b0010, 32'h0000_6600, 3, 4'b0010, 2'd1, 8'h66, 1'b0);
        checkOutput("errgo_sticky", 32'(bus.err_tmo), 32'h1);

        // Clear held through a second timeout: clear acts, then set wins on the timeout edge
        applyStimulus(4'b0001, 32'h0000_0077, 1'b0, 1'b0);
        tick();
        checkOutput("race_ready", 32'(bus.req_ready), 32'h1);
        bus.req_valid = 4'b0000;
        tick();
        tick();
        bus.err_clr = 1'b1;
        repeat (ACK_TMO - 1) tick();
        checkOutput("race_cleared", 32'(bus.err_tmo), 32'h0);
        tick();
        checkOutput("race_setwins", 32'(bus.err_tmo), 32'h1);
        bus.err_clr = 1'b0;
        tick();
        checkOutput("err_hold", 32'(bus.err_tmo), 32'h1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        checkOutput("err_clr", 32'(bus.err_tmo), 32'h0);

        // Blocked by tx_busy, and a valid withdrawn before grant leaves no trace
        doReset();
        applyStimulus(4'b0100, 32'h00CC_0077, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("blk_ready", 32'(bus.req_ready), 32'h0);
            checkOutput("blk_abusy", 32'(bus.arb_busy), 32'h0);
        end
        applyStimulus(4'b0000, 32'h00CC_0077, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("drop_ready", 32'(bus.req_ready), 32'h0);
        checkOutput("drop_gnt", 32'(bus.gnt_id), 32'h0);
        checkOutput("drop_data", 32'(bus.tx_data), 32'h0);
        applyStimulus(4'b0001, 32'h00CC_0077, 1'b1, 1'b0);
        tick();
        checkOutput("blk2_ready", 32'(bus.req_ready), 32'h0);
        bus.tx_busy = 1'b0;
        tick();
        checkOutput("unblk_ready", 32'(bus.req_ready), 32'h1);
        checkOutput("unblk_data", 32'(bus.tx_data), 32'h77);

        // Reset while tx_start is high, then reset while waiting in the ack phase
        doReset();
        applyStimulus(4'b0100, 32'h00BE_0000, 1'b0, 1'b0);
        tick();
        bus.req_valid = 4'b0000;
        tick();
        checkOutput("rs_start_pre", 32'(bus.tx_start), 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("rs_start", 32'(bus.tx_start), 32'h0);
        checkOutput("rs_data", 32'(bus.tx_data), 32'h0);
        tick();
        rst = 1'b0;
        applyStimulus(4'b0100, 32'h00BE_0000, 1'b0, 1'b0);
        tick();
        checkOutput("ra_ready", 32'(bus.req_ready), 32'h4);
        bus.req_valid = 4'b0000;
        repeat (5) tick();
        checkOutput("ra_pre_abusy", 32'(bus.arb_busy), 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("ra_ready0", 32'(bus.req_ready), 32'h0);
        checkOutput("ra_gnt", 32'(bus.gnt_id), 32'h0);
        checkOutput("ra_data", 32'(bus.tx_data), 32'h0);
        checkOutput("ra_abusy", 32'(bus.arb_busy), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("ra_after", 32'(bus.arb_busy), 32'h0);

        // Random traffic against a transaction-level model
        doReset();
        pending    = '0;
        last_rr    = NREQ - 1;
        last_gnt   = '0;
        last_data  = '0;
        free_from  = 0;
        busy_on    = -100;
        busy_off   = -100;
        start_at   = -100;
        grant_edge = -100;
        for (int i = 0; i < NREQ; i++) dat[i] = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pending[i] && $urandom_range(0, 3) == 0) begin
                    pending[i] = 1'b1;
                    dat[i]     = 8'($urandom_range(0, 255));
                end
            end
            v = pending;
            d = {dat[3], dat[2], dat[1], dat[0]};
            applyStimulus(v, d, (cyc > busy_on && cyc <= busy_off), 1'b0);
            tick();
            exp_ready = '0;
            if (cyc >= free_from && v != 4'b0000) begin
                w          = pick(last_rr, v);
                exp_ready  = 4'(4'b0001 << w);
                last_rr    = w;
                last_gnt   = 2'(w);
                last_data  = dat[w];
                pending[w] = 1'b0;
                grant_edge = cyc;
                start_at   = cyc + 1;
                busy_on    = cyc + 1 + $urandom_range(1, 3);
                busy_off   = busy_on + $urandom_range(1, 6);
                free_from  = busy_off + 2;
            end
            checkOutput("rnd_ready", 32'(bus.req_ready), 32'(exp_ready));
            checkOutput("rnd_gnt", 32'(bus.gnt_id), 32'(last_gnt));
            checkOutput("rnd_data", 32'(bus.tx_data), 32'(last_data));
            checkOutput("rnd_start", 32'(bus.tx_start), 32'(cyc == start_at));
            checkOutput("rnd_abusy", 32'(bus.arb_busy), 32'(cyc >= grant_edge && cyc <= busy_off));
        end
        checkOutput("rnd_err", 32'(bus.err_tmo), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
